// File: rtl/spi_tft_pattern_gen_if.sv
// Pixel-source handshake between the SPI TFT flush stage (master) and the
// pattern generator (slave). The flush stage drives mode select, per-byte
// update pulses and end-of-frame sync. The generator returns the current
// byte, the completed-frame count and a busy flag.
interface spi_tft_pattern_gen_if;
    logic [1:0] mode_i;
    logic       updte_i;
    logic       fsync_i;
    logic [7:0] data_o;
    logic [7:0] frame_cnt_o;
    logic       busy_o;

    modport master (
        output mode_i, updte_i, fsync_i,
        input  data_o, frame_cnt_o, busy_o
    );

    modport slave (
        input  mode_i, updte_i, fsync_i,
        output data_o, frame_cnt_o, busy_o
    );
endinterface

// File: rtl/spi_tft_pattern_gen.sv
// RGB565 test-pattern source for full-screen SPI TFT refreshes.
// It streams the image high byte first, one byte per update pulse.
// It walks x/y raster counters and supports four patterns:
//   0 = solid colour, 1 = eight vertical bars, 2 = 16x16 checkerboard,
//   3 = gradient.
// Optional macro PATTERN_SCROLL_EN rotates the colour bars by frame_cnt[5:3].
// The rotation offset is latched at frame sync.
module spi_tft_pattern_gen #(
    parameter logic [15:0] SCREEN_WIDTH  = 16'd320,
    parameter logic [15:0] SCREEN_HEIGHT = 16'd240,
    parameter logic [15:0] SOLID_COLOR   = 16'hF800
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    spi_tft_pattern_gen_if.slave   bus
);

    // Bars are found by counting pixels rather than dividing x.
    localparam logic [15:0] BAR_W = SCREEN_WIDTH >> 3;

    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        phase_q, phase_d;
    logic [15:0] bar_pos_q, bar_pos_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        busy_q, busy_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  color_idx;
    logic [15:0] pixel;
`ifdef PATTERN_SCROLL_EN
    logic [2:0]  scroll_q, scroll_d;
`endif

    // Next-state raster/frame logic, with the pixel taken from the post-update position
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        phase_d     = phase_q;
        bar_pos_d   = bar_pos_q;
        bar_idx_d   = bar_idx_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        busy_d      = busy_q;
`ifdef PATTERN_SCROLL_EN
        scroll_d    = scroll_q;
`endif
        if (sys_rst) begin
            // Mirrors the reset values so data_o shows P(0,0) for the sampled mode
            x_d         = '0;
            y_d         = '0;
            phase_d     = 1'b0;
            bar_pos_d   = '0;
            bar_idx_d   = '0;
            mode_d      = bus.mode_i;
            frame_cnt_d = '0;
            busy_d      = 1'b0;
`ifdef PATTERN_SCROLL_EN
            scroll_d    = '0;
`endif
        end else if (bus.fsync_i) begin
            // Frame sync takes priority; an update in the same cycle is dropped
            x_d         = '0;
            y_d         = '0;
            phase_d     = 1'b0;
            bar_pos_d   = '0;
            bar_idx_d   = '0;
            mode_d      = bus.mode_i;
            frame_cnt_d = frame_cnt_q + 8'd1;
            busy_d      = 1'b0;
`ifdef PATTERN_SCROLL_EN
            scroll_d    = frame_cnt_d[5:3];
`endif
        end else if (bus.updte_i) begin
            busy_d = 1'b1;
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (x_q == SCREEN_WIDTH - 16'd1) begin
                    x_d       = '0;
                    bar_pos_d = '0;
                    bar_idx_d = '0;
                    // Defensive wrap in case the frame sync never arrives
                    y_d = (y_q == SCREEN_HEIGHT - 16'd1) ? 16'd0 : y_q + 16'd1;
                end else begin
                    x_d = x_q + 16'd1;
                    if (bar_pos_q == BAR_W - 16'd1) begin
                        bar_pos_d = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_pos_d = bar_pos_q + 16'd1;
                    end
                end
            end
        end

`ifdef PATTERN_SCROLL_EN
        color_idx = bar_idx_d + scroll_d;
`else
        color_idx = bar_idx_d;
`endif

        case (mode_d)
            2'd0: pixel = SOLID_COLOR;
            2'd1: begin
                case (color_idx)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd2:    pixel = (x_d[4] ^ y_d[4]) ? 16'hFFFF : 16'h0000;
            default: pixel = {x_d[8:4], y_d[7:2], ~x_d[8:4]};
        endcase

        data_d = phase_d ? pixel[7:0] : pixel[15:8];
    end

    // State and output registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            x_q         <= '0;
            y_q         <= '0;
            phase_q     <= 1'b0;
            bar_pos_q   <= '0;
            bar_idx_q   <= '0;
            mode_q      <= bus.mode_i;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            data_q      <= data_d;
`ifdef PATTERN_SCROLL_EN
            scroll_q    <= '0;
`endif
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            phase_q     <= phase_d;
            bar_pos_q   <= bar_pos_d;
            bar_idx_q   <= bar_idx_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
`ifdef PATTERN_SCROLL_EN
            scroll_q    <= scroll_d;
`endif
        end
    end

    assign bus.data_o      = data_q;
    assign bus.frame_cnt_o = frame_cnt_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_spi_tft_pattern_gen.sv
// Directed self-checking bench for spi_tft_pattern_gen.
// Instance A uses a 16x4 screen and instance B uses a 32x32 screen for the checkerboard.
module tb_spi_tft_pattern_gen;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   pass_cnt;
    int   check_cnt;

    spi_tft_pattern_gen_if if_a ();
    spi_tft_pattern_gen_if if_b ();

    spi_tft_pattern_gen #(
        .SCREEN_WIDTH (16'd16),
        .SCREEN_HEIGHT(16'd4)
    ) dut_a (
        .sys_clk(clk),
        .sys_rst(rst_a),
        .bus    (if_a)
    );

    spi_tft_pattern_gen #(
        .SCREEN_WIDTH (16'd32),
        .SCREEN_HEIGHT(16'd32)
    ) dut_b (
        .sys_clk(clk),
        .sys_rst(rst_b),
        .bus    (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_a(input logic [1:0] mode);
        @(negedge clk);
        if_a.mode_i = mode;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic upd_a();
        @(negedge clk);
        if_a.updte_i = 1'b1;
        @(negedge clk);
        if_a.updte_i = 1'b0;
    endtask

    task automatic fsync_a();
        @(negedge clk);
        if_a.fsync_i = 1'b1;
        @(negedge clk);
        if_a.fsync_i = 1'b0;
    endtask

    task automatic upd_b();
        @(negedge clk);
        if_b.updte_i = 1'b1;
        @(negedge clk);
        if_b.updte_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_a(2'd0);
        check_cnt++;
        if (if_a.data_o !== 8'hF8) $display("FAIL reset_data got %h want f8", if_a.data_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.frame_cnt_o !== 8'd0) $display("FAIL reset_frame got %0d want 0", if_a.frame_cnt_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", if_a.busy_o);
        else pass_cnt++;
        upd_a();
        check_cnt++;
        if (if_a.data_o !== 8'h00) $display("FAIL solid_lo got %h want 00", if_a.data_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.busy_o !== 1'b1) $display("FAIL busy_rise got %b want 1", if_a.busy_o);
        else pass_cnt++;
        upd_a();
        check_cnt++;
        if (if_a.data_o !== 8'hF8) $display("FAIL solid_px1_hi got %h want f8", if_a.data_o);
        else pass_cnt++;
        $display("test_reset done: data=%h", if_a.data_o);
    endtask

    task automatic test_bars();
        logic [15:0] bars [8];
        logic [15:0] col;
        logic [7:0]  exp;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        reset_a(2'd1);
        // Bar width is 2 pixels, so pixel p uses bar p/2
        for (int k = 0; k < 32; k++) begin
            col = bars[k / 4];
            exp = k[0] ? col[7:0] : col[15:8];
            check_cnt++;
            if (if_a.data_o !== exp) $display("FAIL bars_byte%0d got %h want %h", k, if_a.data_o, exp);
            else pass_cnt++;
            upd_a();
        end
        check_cnt++;
        if (if_a.data_o !== 8'hFF) $display("FAIL bars_line_wrap got %h want ff", if_a.data_o);
        else pass_cnt++;
        $display("test_bars done: line streamed, data=%h", if_a.data_o);
    endtask

    task automatic test_checker_frame();
        logic [7:0] exp;
        @(negedge clk);
        if_b.mode_i = 2'd2;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < 2048; k++) begin
            if (k == 0 || k == 32 || k == 33 || k == 1024 || k == 1056 || k == 1057) begin
                // (0,0)=0000, (16,0)=FFFF, (0,16)=FFFF, (16,16)=0000
                exp = (k == 32 || k == 33 || k == 1024) ? 8'hFF : 8'h00;
                check_cnt++;
                if (if_b.data_o !== exp) $display("FAIL checker_byte%0d got %h want %h", k, if_b.data_o, exp);
                else pass_cnt++;
            end
            upd_b();
        end
        check_cnt++;
        if (if_b.busy_o !== 1'b1) $display("FAIL checker_busy got %b want 1", if_b.busy_o);
        else pass_cnt++;
        @(negedge clk);
        if_b.fsync_i = 1'b1;
        @(negedge clk);
        if_b.fsync_i = 1'b0;
        check_cnt++;
        if (if_b.frame_cnt_o !== 8'd1) $display("FAIL checker_frame got %0d want 1", if_b.frame_cnt_o);
        else pass_cnt++;
        check_cnt++;
        if (if_b.data_o !== 8'h00) $display("FAIL checker_restart got %h want 00", if_b.data_o);
        else pass_cnt++;
        check_cnt++;
        if (if_b.busy_o !== 1'b0) $display("FAIL checker_busy_clr got %b want 0", if_b.busy_o);
        else pass_cnt++;
        $display("test_checker_frame done: frame=%0d", if_b.frame_cnt_o);
    endtask

    task automatic test_mode_change();
        reset_a(2'd0);
        upd_a();
        if_a.mode_i = 2'd3;
        upd_a();
        upd_a();
        upd_a();
        // x=2, high byte: mode 0 gives F8, mode 3 would give 00
        check_cnt++;
        if (if_a.data_o !== 8'hF8) $display("FAIL mode_hold got %h want f8", if_a.data_o);
        else pass_cnt++;
        fsync_a();
        check_cnt++;
        if (if_a.data_o !== 8'h00) $display("FAIL grad_hi got %h want 00", if_a.data_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.frame_cnt_o !== 8'd1) $display("FAIL mode_frame got %0d want 1", if_a.frame_cnt_o);
        else pass_cnt++;
        upd_a();
        check_cnt++;
        if (if_a.data_o !== 8'h1F) $display("FAIL grad_lo got %h want 1f", if_a.data_o);
        else pass_cnt++;
        $display("test_mode_change done: data=%h", if_a.data_o);
    endtask

    task automatic test_back_to_back();
        upd_a();
        upd_a();
        // Sync and update together: sync wins, position returns to (0,0) phase 0
        @(negedge clk);
        if_a.fsync_i = 1'b1;
        if_a.updte_i = 1'b1;
        @(negedge clk);
        if_a.fsync_i = 1'b0;
        if_a.updte_i = 1'b0;
        check_cnt++;
        if (if_a.data_o !== 8'h00) $display("FAIL sync_upd_data got %h want 00", if_a.data_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.frame_cnt_o !== 8'd2) $display("FAIL sync_upd_frame got %0d want 2", if_a.frame_cnt_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.busy_o !== 1'b0) $display("FAIL sync_upd_busy got %b want 0", if_a.busy_o);
        else pass_cnt++;
        upd_a();
        check_cnt++;
        if (if_a.data_o !== 8'h1F) $display("FAIL sync_upd_next got %h want 1f", if_a.data_o);
        else pass_cnt++;
        // Reset mid-frame with mode 0 selected
        if_a.mode_i = 2'd0;
        upd_a();
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_cnt++;
        if (if_a.data_o !== 8'hF8) $display("FAIL midrst_data got %h want f8", if_a.data_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.frame_cnt_o !== 8'd0) $display("FAIL midrst_frame got %0d want 0", if_a.frame_cnt_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.busy_o !== 1'b0) $display("FAIL midrst_busy got %b want 0", if_a.busy_o);
        else pass_cnt++;
        $display("test_back_to_back done: data=%h", if_a.data_o);
    endtask

    task automatic test_scroll();
        logic [7:0] exp_lo;
        logic [7:0] exp_bar1;
`ifdef PATTERN_SCROLL_EN
        exp_lo   = 8'hE0;
        exp_bar1 = 8'h07;
`else
        exp_lo   = 8'hFF;
        exp_bar1 = 8'hFF;
`endif
        reset_a(2'd1);
        for (int f = 0; f < 8; f++) begin
            upd_a();
            fsync_a();
        end
        check_cnt++;
        if (if_a.frame_cnt_o !== 8'd8) $display("FAIL scroll_frame got %0d want 8", if_a.frame_cnt_o);
        else pass_cnt++;
        check_cnt++;
        if (if_a.data_o !== 8'hFF) $display("FAIL scroll_hi got %h want ff", if_a.data_o);
        else pass_cnt++;
        upd_a();
        check_cnt++;
        if (if_a.data_o !== exp_lo) $display("FAIL scroll_lo got %h want %h", if_a.data_o, exp_lo);
        else pass_cnt++;
        upd_a();
        upd_a();
        upd_a();
        check_cnt++;
        if (if_a.data_o !== exp_bar1) $display("FAIL scroll_bar1 got %h want %h", if_a.data_o, exp_bar1);
        else pass_cnt++;
        $display("test_scroll done: frame=%0d data=%h", if_a.frame_cnt_o, if_a.data_o);
    endtask

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.mode_i  = 2'd0;
        if_a.updte_i = 1'b0;
        if_a.fsync_i = 1'b0;
        if_b.mode_i  = 2'd2;
        if_b.updte_i = 1'b0;
        if_b.fsync_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        test_reset();
        test_bars();
        test_checker_frame();
        test_mode_change();
        test_back_to_back();
        test_scroll();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
